mont_sq_loop: RTL

- Multi-channel iteration controller for repeated modular squaring, the VDF inner loop.
- Accepts a start value and an iteration count per channel.
- Issues squarings to a pipelined squaring core and feeds each result straight back, so up to CHANNELS independent chains share the core pipeline.
- Returns the final value of each chain through a ready/valid output.
- The core (redundant Montgomery squarer) sits outside the block and is reached through tagged ports.

---
 rtl/mont_loop_pkg.sv | 30 +++
 rtl/mont_loop_rr_arb.sv | 52 +++++
 rtl/mont_sq_loop.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mont_loop_pkg.sv
// ============================================================================
// Module  : mont_loop_pkg
// Brief   : Shared types and defaults for the modular-squaring loop controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mont_loop_pkg;

  localparam int DAT_BITS_DEF = 1024;
  localparam int T_LEN_DEF    = 64;
  localparam int CHANNELS_DEF = 4;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_RUN  = 2'd1,
    CH_DONE = 2'd2
  } ch_state_t;

  typedef logic [DAT_BITS_DEF-1:0] dat_t;
  typedef logic [T_LEN_DEF-1:0]    iter_t;

  // Tag width for a channel count; a single channel still needs one bit.
  function automatic int ch_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mont_loop_rr_arb.sv
// ============================================================================
// Module  : mont_loop_rr_arb
// Brief   : Round-robin arbiter; priority pointer moves past each taken grant.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mont_loop_rr_arb #(
  parameter int N        = 4,
  parameter int IDX_BITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N-1:0]        req,
  input  logic                advance,
  output logic                any,
  output logic [N-1:0]        grant,
  output logic [IDX_BITS-1:0] grant_idx
);

  logic [IDX_BITS-1:0] ptr;

  // Scan from the pointer upwards, wrapping, and take the first requester.
  always_comb begin
    int k;
    k         = 0;
    any       = 1'b0;
    grant     = '0;
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (!any && req[k]) begin
        any       = 1'b1;
        grant[k]  = 1'b1;
        grant_idx = IDX_BITS'(k);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance && any) begin
      if (int'(grant_idx) == N - 1) ptr <= '0;
      else                          ptr <= grant_idx + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mont_sq_loop.sv
// ============================================================================
// Module  : mont_sq_loop
// Brief   : Multi-channel iteration controller feeding a pipelined squarer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mont_sq_loop
  import mont_loop_pkg::*;
#(
  parameter int DAT_BITS = DAT_BITS_DEF,
  parameter int T_LEN    = T_LEN_DEF,
  parameter int CHANNELS = CHANNELS_DEF,
  parameter int CH_BITS  = ch_bits(CHANNELS)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_val,
  output logic                o_rdy,
  input  logic [CH_BITS-1:0]  i_ch,
  input  logic [DAT_BITS-1:0] i_dat,
  input  logic [T_LEN-1:0]    i_iter,
  output logic                o_core_val,
  output logic [DAT_BITS-1:0] o_core_dat,
  output logic [CH_BITS-1:0]  o_core_tag,
  input  logic                i_core_val,
  input  logic [DAT_BITS-1:0] i_core_dat,
  input  logic [CH_BITS-1:0]  i_core_tag,
  output logic                o_val,
  input  logic                i_rdy,
  output logic [CH_BITS-1:0]  o_ch,
  output logic [DAT_BITS-1:0] o_dat,
  output logic [CHANNELS-1:0] o_busy,
  output logic                o_drop
);

  ch_state_t           state     [CHANNELS];
  ch_state_t           state_nxt [CHANNELS];
  logic [T_LEN-1:0]    rem       [CHANNELS];
  logic [DAT_BITS-1:0] res       [CHANNELS];

  logic                start_ok;
  logic                iter_zero;
  logic                fb_run;
  logic                fb_last;
  logic                hs;
  logic                load;
  logic [CHANNELS-1:0] done_req;
  logic                arb_any;
  logic [CHANNELS-1:0] arb_grant;
  logic [CH_BITS-1:0]  arb_idx;

  // Feedback from the core always wins over a new start, so a start is only
  // offered on cycles without a returning result.
  assign o_rdy     = !i_rst && (state[i_ch] == CH_IDLE) && !i_core_val;
  assign start_ok  = i_val && o_rdy;
  assign iter_zero = (i_iter == '0);
  assign fb_run    = i_core_val && (state[i_core_tag] == CH_RUN);
  assign fb_last   = fb_run && (rem[i_core_tag] == '0);
  assign o_drop    = !i_rst && i_core_val && !fb_run;
  assign hs        = o_val && i_rdy;

  always_comb begin
    o_core_val = 1'b0;
    o_core_dat = i_core_dat;
    o_core_tag = i_core_tag;
    if (fb_run && !fb_last) begin
      o_core_val = 1'b1;
    end else if (start_ok && !iter_zero) begin
      o_core_val = 1'b1;
      o_core_dat = i_dat;
      o_core_tag = i_ch;
    end
  end

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      state_nxt[c] = state[c];
      case (state[c])
        CH_IDLE: begin
          if (start_ok && (i_ch == CH_BITS'(c)))
            state_nxt[c] = iter_zero ? CH_DONE : CH_RUN;
        end
        CH_RUN: begin
          if (fb_last && (i_core_tag == CH_BITS'(c)))
            state_nxt[c] = CH_DONE;
        end
        CH_DONE: begin
          if (hs && (o_ch == CH_BITS'(c)))
            state_nxt[c] = CH_IDLE;
        end
        default: state_nxt[c] = CH_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int c = 0; c < CHANNELS; c++) state[c] <= CH_IDLE;
    end else begin
      for (int c = 0; c < CHANNELS; c++) state[c] <= state_nxt[c];
    end
  end

  // Datapath registers carry no reset; they are always written before use.
  always_ff @(posedge i_clk) begin
    if (start_ok) begin
      if (iter_zero) res[i_ch] <= i_dat;
      else           rem[i_ch] <= i_iter - 1'b1;
    end
    if (fb_run) begin
      if (fb_last) res[i_core_tag] <= i_core_dat;
      else         rem[i_core_tag] <= rem[i_core_tag] - 1'b1;
    end
  end

  // The channel already sitting in the output register must not be granted
  // again while it waits for its handshake.
  always_comb begin
    for (int c = 0; c < CHANNELS; c++)
      done_req[c] = (state[c] == CH_DONE) && !(o_val && (o_ch == CH_BITS'(c)));
  end

  assign load = (!o_val || i_rdy) && arb_any;

  mont_loop_rr_arb #(
    .N        (CHANNELS),
    .IDX_BITS (CH_BITS)
  ) u_arb (
    .clk       (i_clk),
    .rst       (i_rst),
    .req       (done_req),
    .advance   (load),
    .any       (arb_any),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_val <= 1'b0;
      o_ch  <= '0;
      o_dat <= '0;
    end else if (load) begin
      o_val <= 1'b1;
      o_ch  <= arb_idx;
      o_dat <= res[arb_idx];
    end else if (hs) begin
      o_val <= 1'b0;
    end
  end

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_busy
      assign o_busy[c] = (state[c] != CH_IDLE);
    end
  endgenerate

endmodule

`default_nettype wire
